// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding and the
// default number of cycles an access may spend in REQ+WAIT before it is
// abandoned with a bus error.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Access timeout counter.
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero the count (takes priority over enable)
//   enable   : count up by one this cycle
//   done     : count has reached TIMEOUT-1
module mem_timeout_cnt
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access.sv
// Memory-access stage of the CPU pipeline. Accepts one op at a time from the
// execute stage, performs a data-memory load/store through a req/gnt/rvalid
// handshake when needed, and emits a registered one-cycle writeback bundle.
//   ex_*            : op handshake from execute (ready only while idle)
//   write_*/mm_*    : op contents, latched on accept
//   dmem_*          : data-memory request/response
//   wb_*            : writeback bundle, wb_valid_o pulses once per op
//   addr_err_o      : misaligned or load+store op, qualified by wb_valid_o
//   bus_err_o       : memory did not complete within TIMEOUT cycles
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [4:0]  write_r_i,
    input  logic        write_en_i,
    input  logic [31:0] write_data_i,
    input  logic        read_mm_i,
    input  logic        write_mm_i,
    input  logic [31:0] mm_addr_i,
    input  logic [31:0] store_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_write_r_o,
    output logic        wb_write_en_o,
    output logic [31:0] wb_write_data_o,
    output logic        addr_err_o,
    output logic        bus_err_o
);

    state_e      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [4:0]  wr_r_q, wr_r_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_write_r_q, wb_write_r_d;
    logic        wb_write_en_q, wb_write_en_d;
    logic [31:0] wb_write_data_q, wb_write_data_d;
    logic        addr_err_q, addr_err_d;
    logic        bus_err_q, bus_err_d;

    logic cnt_clear, cnt_en, cnt_done;
    logic is_mem, addr_bad;

    assign is_mem   = read_mm_i | write_mm_i;
    assign addr_bad = is_mem && ((mm_addr_i[1:0] != 2'b00) || (read_mm_i && write_mm_i));

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .done   (cnt_done)
    );

    always_comb begin
        state_d         = state_q;
        dmem_req_d      = dmem_req_q;
        dmem_we_d       = dmem_we_q;
        dmem_addr_d     = dmem_addr_q;
        dmem_wdata_d    = dmem_wdata_q;
        wr_r_d          = wr_r_q;
        wr_en_d         = wr_en_q;
        wr_data_d       = wr_data_q;
        wb_valid_d      = 1'b0;
        wb_write_r_d    = wb_write_r_q;
        wb_write_en_d   = wb_write_en_q;
        wb_write_data_d = wb_write_data_q;
        addr_err_d      = addr_err_q;
        bus_err_d       = bus_err_q;
        cnt_clear       = 1'b0;
        cnt_en          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_valid_i) begin
                    wr_r_d       = write_r_i;
                    wr_en_d      = write_en_i;
                    wr_data_d    = write_data_i;
                    dmem_addr_d  = mm_addr_i;
                    dmem_wdata_d = store_data_i;
                    dmem_we_d    = write_mm_i;
                    if (!is_mem || addr_bad) begin
                        // Resolved without touching memory: write back next cycle.
                        wb_valid_d      = 1'b1;
                        wb_write_r_d    = write_r_i;
                        wb_write_en_d   = !is_mem && write_en_i && (write_r_i != 5'd0);
                        wb_write_data_d = write_data_i;
                        addr_err_d      = addr_bad;
                        bus_err_d       = 1'b0;
                    end else begin
                        state_d    = ST_REQ;
                        dmem_req_d = 1'b1;
                        cnt_clear  = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                cnt_en = 1'b1;
                // Timeout takes priority over a grant in the final REQ cycle.
                if (cnt_done) begin
                    state_d         = ST_IDLE;
                    dmem_req_d      = 1'b0;
                    wb_valid_d      = 1'b1;
                    wb_write_r_d    = wr_r_q;
                    wb_write_en_d   = 1'b0;
                    wb_write_data_d = wr_data_q;
                    addr_err_d      = 1'b0;
                    bus_err_d       = 1'b1;
                end else if (dmem_gnt_i) begin
                    state_d    = ST_WAIT;
                    dmem_req_d = 1'b0;
                end
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                // A response in the timeout cycle still completes normally.
                if (dmem_rvalid_i) begin
                    state_d         = ST_IDLE;
                    wb_valid_d      = 1'b1;
                    wb_write_r_d    = wr_r_q;
                    wb_write_en_d   = !dmem_we_q && wr_en_q && (wr_r_q != 5'd0);
                    wb_write_data_d = dmem_we_q ? wr_data_q : dmem_rdata_i;
                    addr_err_d      = 1'b0;
                    bus_err_d       = 1'b0;
                end else if (cnt_done) begin
                    state_d         = ST_IDLE;
                    wb_valid_d      = 1'b1;
                    wb_write_r_d    = wr_r_q;
                    wb_write_en_d   = 1'b0;
                    wb_write_data_d = wr_data_q;
                    addr_err_d      = 1'b0;
                    bus_err_d       = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= '0;
            dmem_wdata_q    <= '0;
            wb_valid_q      <= 1'b0;
            wb_write_r_q    <= '0;
            wb_write_en_q   <= 1'b0;
            wb_write_data_q <= '0;
            addr_err_q      <= 1'b0;
            bus_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            dmem_req_q      <= dmem_req_d;
            dmem_we_q       <= dmem_we_d;
            dmem_addr_q     <= dmem_addr_d;
            dmem_wdata_q    <= dmem_wdata_d;
            wb_valid_q      <= wb_valid_d;
            wb_write_r_q    <= wb_write_r_d;
            wb_write_en_q   <= wb_write_en_d;
            wb_write_data_q <= wb_write_data_d;
            addr_err_q      <= addr_err_d;
            bus_err_q       <= bus_err_d;
        end
    end

    // Op fields are only consumed after an accept, so they need no reset.
    always_ff @(posedge clk) begin
        wr_r_q    <= wr_r_d;
        wr_en_q   <= wr_en_d;
        wr_data_q <= wr_data_d;
    end

    assign ex_ready_o      = (state_q == ST_IDLE);
    assign dmem_req_o      = dmem_req_q;
    assign dmem_we_o       = dmem_we_q;
    assign dmem_addr_o     = dmem_addr_q;
    assign dmem_wdata_o    = dmem_wdata_q;
    assign wb_valid_o      = wb_valid_q;
    assign wb_write_r_o    = wb_write_r_q;
    assign wb_write_en_o   = wb_write_en_q;
    assign wb_write_data_o = wb_write_data_q;
    assign addr_err_o      = addr_err_q;
    assign bus_err_o       = bus_err_q;

endmodule
